// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports
// (port 1 wins on collision), optional write bypass and hardwired zero, plus a busy scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  input  logic                       iss_v,
  input  logic [ADDR_W-1:0]          iss_a,
  output logic [NUM_RD-1:0]          rbusy,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);
  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] mem;
  logic [NREG-1:0]             busy;
  logic [NREG-1:0]             busy_nxt;
  logic                        wr0_ok;
  logic                        wr1_ok;

  assign wr0_ok = we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1_ok = we1 && !((ZERO_REG != 0) && (wa1 == '0));

  // Issue is applied last so a younger producer keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (we0) busy_nxt[wa0] = 1'b0;
    if (we1) busy_nxt[wa1] = 1'b0;
    if (iss_v) busy_nxt[iss_a] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      if (wr0_ok) mem[wa0] <= wd0;
      if (wr1_ok) mem[wa1] <= wd1;
      busy <= busy_nxt;
    end
  end

  assign busy_vec = busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = ra[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem[addr];
      if ((BYPASS != 0) && we0 && (wa0 == addr)) data = wd0;
      if ((BYPASS != 0) && we1 && (wa1 == addr)) data = wd1;
      if ((ZERO_REG != 0) && (addr == '0)) data = '0;
    end

    assign rd[k*DATA_W +: DATA_W] = data;
    // Registered state only: a same-cycle writeback does not hide the flag.
    assign rbusy[k] = busy[addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (bypass, zero reg) and a 4-read,
// 8-entry, 16-bit instance without bypass or zero reg, both against array models.
module tb_regfile_mp;
  logic clk;
  logic rst;

  logic        a_we0, a_we1, a_iss_v;
  logic [4:0]  a_wa0, a_wa1, a_iss_a;
  logic [31:0] a_wd0, a_wd1;
  logic [9:0]  a_ra;
  logic [63:0] a_rd;
  logic [1:0]  a_rbusy;
  logic [31:0] a_busy_vec;

  logic        b_we0, b_we1, b_iss_v;
  logic [2:0]  b_wa0, b_wa1, b_iss_a;
  logic [15:0] b_wd0, b_wd1;
  logic [11:0] b_ra;
  logic [63:0] b_rd;
  logic [3:0]  b_rbusy;
  logic [7:0]  b_busy_vec;

  int n_pass;
  int n_checks;

  logic [31:0] ma_mem [32];
  logic [31:0] ma_busy;
  logic [15:0] mb_mem [8];
  logic [7:0]  mb_busy;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst),
    .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0),
    .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
    .ra(a_ra), .rd(a_rd),
    .iss_v(a_iss_v), .iss_a(a_iss_a),
    .rbusy(a_rbusy), .busy_vec(a_busy_vec)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst),
    .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0),
    .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
    .ra(b_ra), .rd(b_rd),
    .iss_v(b_iss_v), .iss_a(b_iss_a),
    .rbusy(b_rbusy), .busy_vec(b_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference read, straight from the priority list: zero reg, port 1, port 0, storage.
  function automatic logic [31:0] a_exp_rd(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (a_we1 && a_wa1 == addr) return a_wd1;
    if (a_we0 && a_wa0 == addr) return a_wd0;
    return ma_mem[addr];
  endfunction

  function automatic logic [15:0] b_exp_rd(input logic [2:0] addr);
    return mb_mem[addr];
  endfunction

  task automatic models_clear();
    for (int i = 0; i < 32; i++) ma_mem[i] = '0;
    for (int i = 0; i < 8; i++) mb_mem[i] = '0;
    ma_busy = '0;
    mb_busy = '0;
  endtask

  task automatic models_edge();
    if (a_we0 && a_wa0 != 5'd0) ma_mem[a_wa0] = a_wd0;
    if (a_we1 && a_wa1 != 5'd0) ma_mem[a_wa1] = a_wd1;
    if (a_we0) ma_busy[a_wa0] = 1'b0;
    if (a_we1) ma_busy[a_wa1] = 1'b0;
    if (a_iss_v) ma_busy[a_iss_a] = 1'b1;
    ma_busy[0] = 1'b0;
    if (b_we0) mb_mem[b_wa0] = b_wd0;
    if (b_we1) mb_mem[b_wa1] = b_wd1;
    if (b_we0) mb_busy[b_wa0] = 1'b0;
    if (b_we1) mb_busy[b_wa1] = 1'b0;
    if (b_iss_v) mb_busy[b_iss_a] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) models_edge();
    #1;
  endtask

  task automatic idle_inputs();
    a_we0 = 0; a_we1 = 0; a_iss_v = 0; a_wa0 = 0; a_wa1 = 0; a_iss_a = 0; a_wd0 = 0; a_wd1 = 0;
    b_we0 = 0; b_we1 = 0; b_iss_v = 0; b_wa0 = 0; b_wa1 = 0; b_iss_a = 0; b_wd0 = 0; b_wd1 = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    a_ra = {5'd5, 5'd3};
    b_ra = {3'd0, 3'd0, 3'd5, 3'd3};
    #1 rst = 1'b0;
    models_clear();
    #2;
    n_checks++; if (a_rd !== 64'd0) $display("FAIL reset_a_rd: got %h want %h", a_rd, 64'd0); else n_pass++;
    n_checks++; if (a_busy_vec !== 32'd0) $display("FAIL reset_a_busy: got %h want %h", a_busy_vec, 32'd0); else n_pass++;
    n_checks++; if (a_rbusy !== 2'd0) $display("FAIL reset_a_rbusy: got %b want %b", a_rbusy, 2'd0); else n_pass++;
    n_checks++; if (b_rd !== 64'd0) $display("FAIL reset_b_rd: got %h want %h", b_rd, 64'd0); else n_pass++;
    n_checks++; if (b_busy_vec !== 8'd0) $display("FAIL reset_b_busy: got %h want %h", b_busy_vec, 8'd0); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_write_bypass();
    a_we0 = 1; a_wa0 = 5'd3; a_wd0 = 32'hDEADBEEF; a_ra = {5'd5, 5'd3};
    b_we0 = 1; b_wa0 = 3'd3; b_wd0 = 16'hBEEF;     b_ra = {3'd0, 3'd0, 3'd5, 3'd3};
    @(negedge clk);
    n_checks++; if (a_rd[31:0] !== 32'hDEADBEEF) $display("FAIL bypass_same_cycle: got %h want %h", a_rd[31:0], 32'hDEADBEEF); else n_pass++;
    n_checks++; if (b_rd[15:0] !== 16'h0) $display("FAIL nobypass_old_value: got %h want %h", b_rd[15:0], 16'h0); else n_pass++;
    tick();
    a_we0 = 0; b_we0 = 0;
    @(negedge clk);
    n_checks++; if (a_rd[31:0] !== 32'hDEADBEEF) $display("FAIL bypass_after_edge: got %h want %h", a_rd[31:0], 32'hDEADBEEF); else n_pass++;
    n_checks++; if (b_rd[15:0] !== 16'hBEEF) $display("FAIL nobypass_after_edge: got %h want %h", b_rd[15:0], 16'hBEEF); else n_pass++;
    tick();
  endtask

  task automatic test_dual_write();
    a_we0 = 1; a_we1 = 1; a_wa0 = 5'd7; a_wa1 = 5'd7; a_wd0 = 32'h11; a_wd1 = 32'h22; a_ra = {5'd3, 5'd7};
    b_we0 = 1; b_we1 = 1; b_wa0 = 3'd7; b_wa1 = 3'd7; b_wd0 = 16'h11; b_wd1 = 16'h22; b_ra = {3'd0, 3'd0, 3'd3, 3'd7};
    @(negedge clk);
    n_checks++; if (a_rd[31:0] !== 32'h22) $display("FAIL dual_bypass: got %h want %h", a_rd[31:0], 32'h22); else n_pass++;
    n_checks++; if (b_rd[15:0] !== 16'h0) $display("FAIL dual_nobypass_old: got %h want %h", b_rd[15:0], 16'h0); else n_pass++;
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (a_rd[31:0] !== 32'h22) $display("FAIL dual_stored_a: got %h want %h", a_rd[31:0], 32'h22); else n_pass++;
    n_checks++; if (b_rd[15:0] !== 16'h22) $display("FAIL dual_stored_b: got %h want %h", b_rd[15:0], 16'h22); else n_pass++;
    tick();
  endtask

  task automatic test_zero_reg();
    a_we0 = 1; a_wa0 = 5'd0; a_wd0 = 32'hFFFF_FFFF; a_iss_v = 1; a_iss_a = 5'd0; a_ra = {5'd3, 5'd0};
    b_we0 = 1; b_wa0 = 3'd0; b_wd0 = 16'hFFFF;      b_iss_v = 1; b_iss_a = 3'd0; b_ra = {3'd1, 3'd2, 3'd3, 3'd0};
    @(negedge clk);
    n_checks++; if (a_rd[31:0] !== 32'd0) $display("FAIL zero_bypass: got %h want %h", a_rd[31:0], 32'd0); else n_pass++;
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (a_rd[31:0] !== 32'd0) $display("FAIL zero_stored: got %h want %h", a_rd[31:0], 32'd0); else n_pass++;
    n_checks++; if (a_busy_vec[0] !== 1'b0) $display("FAIL zero_busy: got %b want %b", a_busy_vec[0], 1'b0); else n_pass++;
    n_checks++; if (b_rd[15:0] !== 16'hFFFF) $display("FAIL nozero_stored: got %h want %h", b_rd[15:0], 16'hFFFF); else n_pass++;
    n_checks++; if (b_busy_vec[0] !== 1'b1) $display("FAIL nozero_busy: got %b want %b", b_busy_vec[0], 1'b1); else n_pass++;
    tick();
  endtask

  task automatic test_scoreboard();
    a_iss_v = 1; a_iss_a = 5'd9; a_ra = {5'd9, 5'd3};
    @(negedge clk);
    n_checks++; if (a_busy_vec[9] !== 1'b0) $display("FAIL sb_not_yet: got %b want %b", a_busy_vec[9], 1'b0); else n_pass++;
    tick();
    a_iss_v = 0;
    @(negedge clk);
    n_checks++; if (a_busy_vec[9] !== 1'b1) $display("FAIL sb_set: got %b want %b", a_busy_vec[9], 1'b1); else n_pass++;
    n_checks++; if (a_rbusy[1] !== 1'b1) $display("FAIL sb_rbusy_set: got %b want %b", a_rbusy[1], 1'b1); else n_pass++;
    a_we1 = 1; a_wa1 = 5'd9; a_wd1 = 32'h1234_5678;
    #1;
    n_checks++; if (a_rbusy[1] !== 1'b1) $display("FAIL sb_rbusy_unmasked: got %b want %b", a_rbusy[1], 1'b1); else n_pass++;
    n_checks++; if (a_rd[63:32] !== 32'h1234_5678) $display("FAIL sb_wb_bypass: got %h want %h", a_rd[63:32], 32'h1234_5678); else n_pass++;
    tick();
    a_we1 = 0;
    @(negedge clk);
    n_checks++; if (a_busy_vec[9] !== 1'b0) $display("FAIL sb_cleared: got %b want %b", a_busy_vec[9], 1'b0); else n_pass++;
    n_checks++; if (a_rbusy[1] !== 1'b0) $display("FAIL sb_rbusy_cleared: got %b want %b", a_rbusy[1], 1'b0); else n_pass++;
    tick();
    a_iss_v = 1; a_iss_a = 5'd9; a_we1 = 1; a_wa1 = 5'd9; a_wd1 = 32'h55;
    tick();
    a_we1 = 0;
    @(negedge clk);
    n_checks++; if (a_busy_vec[9] !== 1'b1) $display("FAIL sb_issue_wins: got %b want %b", a_busy_vec[9], 1'b1); else n_pass++;
    tick();
    a_iss_v = 0;
    @(negedge clk);
    n_checks++; if (a_busy_vec[9] !== 1'b1) $display("FAIL sb_reissue: got %b want %b", a_busy_vec[9], 1'b1); else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    a_we0 = 1; a_wa0 = 5'd12; a_wd0 = $urandom | 32'h1; a_iss_v = 1; a_iss_a = 5'd12;
    b_we0 = 1; b_wa0 = 3'd5;  b_wd0 = 16'($urandom) | 16'h1; b_iss_v = 1; b_iss_a = 3'd6;
    tick();
    idle_inputs();
    a_ra = {5'd12, 5'd9};
    b_ra = {3'd6, 3'd7, 3'd3, 3'd5};
    #2 rst = 1'b0;
    models_clear();
    #1;
    n_checks++; if (a_rd !== 64'd0) $display("FAIL async_rst_a_rd: got %h want %h", a_rd, 64'd0); else n_pass++;
    n_checks++; if (a_busy_vec !== 32'd0) $display("FAIL async_rst_a_busy: got %h want %h", a_busy_vec, 32'd0); else n_pass++;
    n_checks++; if (b_rd !== 64'd0) $display("FAIL async_rst_b_rd: got %h want %h", b_rd, 64'd0); else n_pass++;
    n_checks++; if (b_busy_vec !== 8'd0) $display("FAIL async_rst_b_busy: got %h want %h", b_busy_vec, 8'd0); else n_pass++;
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_random_a(input int n);
    logic [31:0] exp;
    logic [4:0]  addr;
    for (int c = 0; c < n; c++) begin
      a_we0 = 1'($urandom); a_we1 = 1'($urandom); a_iss_v = ($urandom_range(0, 3) == 0);
      a_wa0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a_wa1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a_iss_a = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a_wd0 = $urandom; a_wd1 = $urandom;
      for (int k = 0; k < 2; k++)
        a_ra[k*5 +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        addr = a_ra[k*5 +: 5];
        exp = a_exp_rd(addr);
        n_checks++; if (a_rd[k*32 +: 32] !== exp) $display("FAIL rand_a_rd%0d cyc %0d addr %0d: got %h want %h", k, c, addr, a_rd[k*32 +: 32], exp); else n_pass++;
        n_checks++; if (a_rbusy[k] !== ma_busy[addr]) $display("FAIL rand_a_rbusy%0d cyc %0d: got %b want %b", k, c, a_rbusy[k], ma_busy[addr]); else n_pass++;
      end
      n_checks++; if (a_busy_vec !== ma_busy) $display("FAIL rand_a_busy cyc %0d: got %h want %h", c, a_busy_vec, ma_busy); else n_pass++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random_b(input int n);
    logic [15:0] exp;
    logic [2:0]  addr;
    for (int c = 0; c < n; c++) begin
      b_we0 = 1'($urandom); b_we1 = 1'($urandom); b_iss_v = ($urandom_range(0, 2) == 0);
      b_wa0 = 3'($urandom); b_wa1 = 3'($urandom); b_iss_a = 3'($urandom);
      b_wd0 = 16'($urandom); b_wd1 = 16'($urandom);
      b_ra = 12'($urandom);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        addr = b_ra[k*3 +: 3];
        exp = b_exp_rd(addr);
        n_checks++; if (b_rd[k*16 +: 16] !== exp) $display("FAIL rand_b_rd%0d cyc %0d addr %0d: got %h want %h", k, c, addr, b_rd[k*16 +: 16], exp); else n_pass++;
        n_checks++; if (b_rbusy[k] !== mb_busy[addr]) $display("FAIL rand_b_rbusy%0d cyc %0d: got %b want %b", k, c, b_rbusy[k], mb_busy[addr]); else n_pass++;
      end
      n_checks++; if (b_busy_vec !== mb_busy) $display("FAIL rand_b_busy cyc %0d: got %h want %h", c, b_busy_vec, mb_busy); else n_pass++;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    n_pass = 0;
    n_checks = 0;
    test_reset();
    test_write_bypass();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_async_reset();
    test_random_a(3000);
    test_random_b(10000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined CPU, the successor to the single-cycle register file. It provides NUM_RD combinational read ports, two synchronous write ports with fixed priority, optional write-to-read bypass, and an optional hardwired-zero register. A per-register busy scoreboard lets decode detect pending writebacks. It sits between decode (reads and issue) and writeback (writes).

## Interface
Parameters:
- DATA_W, 32: data word width.
- ADDR_W, 5: register address width; number of registers is NREG = 2**ADDR_W.
- NUM_RD, 2: number of read ports (1..4).
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching reads; 0 = reads return stored contents only.
- ZERO_REG, 1: 1 = register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- we0  input  1  write enable, port 0.
- wa0  input  ADDR_W  write address, port 0.
- wd0  input  DATA_W  write data, port 0.
- we1  input  1  write enable, port 1; has priority over port 0.
- wa1  input  ADDR_W  write address, port 1.
- wd1  input  DATA_W  write data, port 1.
- ra  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd  output  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- iss_v  input  1  issue strobe: mark register iss_a busy.
- iss_a  input  ADDR_W  destination register being issued.
- rbusy  output  NUM_RD  bit k = busy flag of register ra[k].
- busy_vec  output  NREG  full scoreboard; bit i = register i busy.

## Operation
Reset:
- While rst = 0, every register and every busy bit is cleared asynchronously.
- rd therefore reads all zeros, and rbusy and busy_vec are 0.

Write:
- On each rising edge, port 0 writes wd0 to register wa0 when we0 = 1.
- Port 1 writes wd1 to register wa1 when we1 = 1.
- If both ports target the same address, only wd1 is stored.
- With ZERO_REG = 1, writes to address 0 are dropped.

Read (combinational) for port k:
- ZERO_REG = 1 and ra[k] = 0: returns 0.
- Else if BYPASS = 1, we1 = 1 and wa1 = ra[k]: returns wd1.
- Else if BYPASS = 1, we0 = 1 and wa0 = ra[k]: returns wd0.
- Otherwise: returns the stored register ra[k].

Scoreboard, evaluated per register i on each edge:
- Set when iss_v = 1 and iss_a = i.
- Else cleared when (we0 = 1 and wa0 = i) or (we1 = 1 and wa1 = i).
- Otherwise holds.
- Issue wins over a simultaneous writeback to the same register, because the newly issued producer is younger.
- With ZERO_REG = 1, bit 0 is held at 0.
- rbusy[k] = busy_vec[ra[k]]. It reflects registered state only; a same-cycle writeback does not mask it.
- Marking an already-busy register busy again is legal; the bit stays 1.

Assertion deasserting mid-operation: reset is asynchronous, so any in-flight write or issue in that cycle is lost.

## Timing
- Write latency is 1 edge. With BYPASS = 0, a read of the written address returns the new value in the cycle after the edge. With BYPASS = 1, it returns the new value in the same cycle.
- Read latency is 0: rd is purely combinational from ra, the register array, and the write ports.
- busy_vec and rbusy update 1 edge after iss_v or a writeback.
- Reset release: the first edge after rst rises may write.
- The bypass path must not form a loop. wd* must not depend combinationally on rd in the parent design.

## Test plan
- Reset, then read ra = {5, 3}: rd = 0 and busy_vec = 0. Assert rst = 0 asynchronously mid-cycle after writes: rd returns 0 immediately.
- Write we0 = 1, wa0 = 3, wd0 = 0xDEADBEEF with BYPASS = 1: rd[0] (ra[0] = 3) = 0xDEADBEEF in the same cycle and after the edge. With BYPASS = 0, the old value before the edge and 0xDEADBEEF after.
- Dual write to the same address: wa0 = wa1 = 7, wd0 = 0x11, wd1 = 0x22. Read of reg 7 returns 0x22 in the bypass cycle and after the edge.
- Writes to reg 0 with ZERO_REG = 1: wd0 = 0xFFFF_FFFF to address 0 reads 0 and busy_vec[0] stays 0. With ZERO_REG = 0, the same write reads 0xFFFF_FFFF.
- Scoreboard: issue reg 9 -> busy_vec[9] = 1 next cycle and rbusy[1] = 1 for ra[1] = 9. Writeback we1 = 1, wa1 = 9 -> bit cleared next cycle. Simultaneous iss_a = 9 with writeback to 9 -> bit stays 1.
- Parameter sweep: NUM_RD = 4, ADDR_W = 3, DATA_W = 16. Random writes, issues and reads checked against a reference model for 10k cycles with no mismatch.
